// File: rtl/bp_mem_rr_arbiter.sv
// Round-robin arbiter that lets num_req_p BedRock requesters share one bp_mem.
// Accepted command IDs are queued in order so that in-order responses return to their issuer.
module bp_mem_rr_arbiter #(
   parameter int num_req_p           = 2,
   parameter int max_outstanding_p   = 8,
   parameter int cce_mem_msg_width_p = 64
) (
   input  logic                                     clk_i,
   input  logic                                     reset_n_i,
   input  logic [num_req_p*cce_mem_msg_width_p-1:0] req_cmd_i,
   input  logic [num_req_p-1:0]                     req_cmd_v_i,
   output logic [num_req_p-1:0]                     req_cmd_ready_and_o,
   output logic [num_req_p*cce_mem_msg_width_p-1:0] req_resp_o,
   output logic [num_req_p-1:0]                     req_resp_v_o,
   input  logic [num_req_p-1:0]                     req_resp_yumi_i,
   output logic [cce_mem_msg_width_p-1:0]           mem_cmd_o,
   output logic                                     mem_cmd_v_o,
   input  logic                                     mem_cmd_ready_and_i,
   input  logic [cce_mem_msg_width_p-1:0]           mem_resp_i,
   input  logic                                     mem_resp_v_i,
   output logic                                     mem_resp_yumi_o,
   output logic                                     err_o
);

   localparam int id_w_lp  = $clog2(num_req_p);
   localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
   localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

   typedef logic [id_w_lp-1:0]  id_t;
   typedef logic [ptr_w_lp-1:0] ptr_t;

   // Handshakes: a command moves when valid and ready_and are both high in the same
   // cycle; a response moves when the consumer raises yumi while the response is valid.

   function automatic id_t rr_idx(input id_t base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= num_req_p) s = s - num_req_p;
      return id_t'(s[id_w_lp-1:0]);
   endfunction

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (int'(p) == max_outstanding_p - 1) ? '0 : ptr_t'(p + 1'b1);
   endfunction

   id_t                 rr_ptr_r;
   id_t                 lock_id_r;
   logic                lock_r;
   id_t                 fifo_mem_r [max_outstanding_p];
   ptr_t                wr_ptr_r;
   ptr_t                rd_ptr_r;
   logic [cnt_w_lp-1:0] count_r;
   logic                err_r;

   id_t                 rr_pick;
   id_t                 grant_id;
   id_t                 head_id;
   logic                found;
   logic                fifo_full;
   logic                fifo_empty;
   logic                cmd_v;
   logic                xfer;
   logic                resp_v;
   logic                pop;
   logic                err_evt;
   logic [num_req_p-1:0] head_mask;

   always_comb begin
      found   = 1'b0;
      rr_pick = rr_ptr_r;
      for (int i = 0; i < num_req_p; i++) begin
         if (!found && req_cmd_v_i[rr_idx(rr_ptr_r, i)]) begin
            found   = 1'b1;
            rr_pick = rr_idx(rr_ptr_r, i);
         end
      end
   end

   // A presented but unaccepted command pins the grant so valid/data cannot move.
   assign grant_id   = lock_r ? lock_id_r : rr_pick;
   assign fifo_full  = (count_r == cnt_w_lp'(max_outstanding_p));
   assign fifo_empty = (count_r == '0);
   assign cmd_v      = reset_n_i & ~fifo_full & req_cmd_v_i[grant_id];
   assign xfer       = cmd_v & mem_cmd_ready_and_i;
   assign head_id    = fifo_mem_r[rd_ptr_r];

   always_comb begin
      mem_cmd_o           = '0;
      req_cmd_ready_and_o = '0;
      head_mask           = '0;
      for (int i = 0; i < num_req_p; i++) begin
         if (int'(grant_id) == i) begin
            if (reset_n_i) mem_cmd_o = req_cmd_i[i*cce_mem_msg_width_p +: cce_mem_msg_width_p];
            req_cmd_ready_and_o[i] = xfer;
         end
         head_mask[i] = ~fifo_empty & (int'(head_id) == i);
      end
   end

   assign resp_v          = reset_n_i & mem_resp_v_i & ~fifo_empty;
   assign req_resp_v_o    = head_mask & {num_req_p{resp_v}};
   assign pop             = resp_v & |(req_resp_yumi_i & head_mask);
   assign mem_resp_yumi_o = pop;
   assign mem_cmd_v_o     = cmd_v;
   assign req_resp_o      = reset_n_i ? {num_req_p{mem_resp_i}} : '0;
   assign err_evt         = (mem_resp_v_i & fifo_empty) | |(req_resp_yumi_i & ~head_mask);
   assign err_o           = err_r;

   always_ff @(posedge clk_i) begin
      if (xfer) fifo_mem_r[wr_ptr_r] <= grant_id;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rr_ptr_r  <= '0;
         lock_id_r <= '0;
         lock_r    <= 1'b0;
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
         err_r     <= 1'b0;
      end else begin
         if (xfer) begin
            lock_r   <= 1'b0;
            rr_ptr_r <= rr_idx(grant_id, 1);
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end else if (cmd_v) begin
            lock_r    <= 1'b1;
            lock_id_r <= grant_id;
         end
         if (pop) rd_ptr_r <= ptr_inc(rd_ptr_r);
         case ({xfer, pop})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
         err_r <= err_r | err_evt;
      end
   end

endmodule
